// File: rtl/pipelined_cla_adder.sv
// Pipelined W-bit add/subtract: one SEG-bit carry-lookahead segment is resolved per stage,
// with the inter-segment carry and the not-yet-used operand bits skewed through registers.
module pipelined_cla_adder #(
  parameter int W   = 64,
  parameter int SEG = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int NSEG = W / SEG;
  localparam int NGRP = SEG / 4;

  if (W % SEG != 0) begin : g_chk_w
    $error("pipelined_cla_adder: W must be a multiple of SEG");
  end
  if ((SEG % 4 != 0) || (SEG < 4)) begin : g_chk_seg
    $error("pipelined_cla_adder: SEG must be a non-zero multiple of 4");
  end

  // Returns {carry_out, sum}. Group carries are flat sums of products of the group
  // generate/propagate terms, so no carry ripples from one 4-bit group into the next.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  p;
    logic [SEG-1:0]  c;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic            t;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t &= gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t &= gp[m];
        gc[j] |= t;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[NGRP], p ^ c};
  endfunction

  logic adv;
  logic ovf_d;
  logic ovf_q;

  // Every stage advances together; the only stall source is a held output beat.
  always_comb begin
    adv = !g_stage[NSEG-1].vld_q || out_ready;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int OW = W - k * SEG;
    localparam int RW = (k + 1) * SEG;
    logic [OW-1:0]  op_a;
    logic [OW-1:0]  op_b;
    logic           seg_cin;
    logic [SEG:0]   seg_r;
    logic           vld_d;
    logic           vld_q;
    logic           cy_d;
    logic           cy_q;
    logic [RW-1:0]  res_d;
    logic [RW-1:0]  res_q;

    if (k == 0) begin : g_first
      always_comb begin
        op_a    = a;
        op_b    = sub ? ~b : b;
        seg_cin = sub ? 1'b1 : c_in;
        seg_r   = cla_seg(op_a[SEG-1:0], op_b[SEG-1:0], seg_cin);
        vld_d   = vld_q;
        cy_d    = cy_q;
        res_d   = res_q;
        if (adv) begin
          vld_d = in_valid;
          cy_d  = seg_r[SEG];
          res_d = seg_r[SEG-1:0];
        end
      end
    end else begin : g_next
      always_comb begin
        op_a    = g_skew[k-1].opa_q;
        op_b    = g_skew[k-1].opb_q;
        seg_cin = g_stage[k-1].cy_q;
        seg_r   = cla_seg(op_a[SEG-1:0], op_b[SEG-1:0], seg_cin);
        vld_d   = vld_q;
        cy_d    = cy_q;
        res_d   = res_q;
        if (adv) begin
          vld_d = g_stage[k-1].vld_q;
          cy_d  = seg_r[SEG];
          res_d = {seg_r[SEG-1:0], g_stage[k-1].res_q};
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        res_q <= res_d;
      end
    end
  end

  // Skew registers carry only the operand bits that later stages still need.
  for (genvar k = 0; k < NSEG - 1; k++) begin : g_skew
    localparam int SW = W - (k + 1) * SEG;
    logic [SW-1:0] opa_d;
    logic [SW-1:0] opa_q;
    logic [SW-1:0] opb_d;
    logic [SW-1:0] opb_q;

    always_comb begin
      opa_d = opa_q;
      opb_d = opb_q;
      if (adv) begin
        opa_d = g_stage[k].op_a[W-k*SEG-1:SEG];
        opb_d = g_stage[k].op_b[W-k*SEG-1:SEG];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        opa_q <= '0;
        opb_q <= '0;
      end else begin
        opa_q <= opa_d;
        opb_q <= opb_d;
      end
    end
  end

  // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = g_stage[NSEG-1].seg_r[SEG-1] ^ g_stage[NSEG-1].op_a[SEG-1] ^
              g_stage[NSEG-1].op_b[SEG-1] ^ g_stage[NSEG-1].seg_r[SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = g_stage[NSEG-1].vld_q;
  assign sum       = g_stage[NSEG-1].res_q;
  assign c_out     = g_stage[NSEG-1].cy_q;
  assign ovf       = ovf_q;

endmodule
